// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage for a small in-order core. Drives a 16-bit PC onto a
//   combinational program ROM and registers the returned 28-bit word for
//   decode/execute. The NOP opcode is consumed here as a timed delay: the
//   NOP itself is never forwarded, and a non-zero immediate N holds fetch
//   for N additional cycles. Branch redirects and downstream stalls are
//   handled with priority Reset > branch > stall > normal fetch.
//
// Ports
//   Clock          in   1   rising-edge clock
//   Reset          in   1   synchronous, active-high reset
//   iInstruction   in  28   ROM word at oAddress ([27:24] opcode, [23:0] imm)
//   iBranchTaken   in   1   one-cycle redirect request from execute
//   iBranchTarget  in  16   redirect address, used only with iBranchTaken
//   iStall         in   1   downstream hold request
//   oAddress       out 16   ROM address (the PC register)
//   oInstruction   out 28   registered instruction, BUBBLE when not valid
//   oValid         out  1   oInstruction must be executed this cycle
//   oPC            out 16   address the issued instruction came from
//   oDelayBusy     out  1   high while a NOP delay is counting
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [3:0]  OP_NOP = 4'd0,
    parameter logic [27:0] BUBBLE = {OP_NOP, 24'd0}
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [27:0] iInstruction,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    input  logic        iStall,
    output logic [15:0] oAddress,
    output logic [27:0] oInstruction,
    output logic        oValid,
    output logic [15:0] oPC,
    output logic        oDelayBusy
);

    localparam int unsigned PC_W   = 16;
    localparam int unsigned INSN_W = 28;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned OP_W   = 4;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DELAY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [INSN_W-1:0]   insn_q, insn_d;
    logic                valid_q, valid_d;
    logic [PC_W-1:0]     opc_q, opc_d;
    logic                busy_q, busy_d;

    // Decoded view of the word currently returned by the ROM.
    logic [OP_W-1:0]     fetch_op;
    logic [CNT_W-1:0]    fetch_imm;
    logic                fetch_is_nop;
    logic                fetch_is_delay;

    assign fetch_op       = iInstruction[INSN_W-1 -: OP_W];
    assign fetch_imm      = iInstruction[CNT_W-1:0];
    assign fetch_is_nop   = (fetch_op == OP_NOP);
    assign fetch_is_delay = fetch_is_nop && (fetch_imm != CNT_W'(0));

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_RUN;
            pc_q    <= PC_W'(0);
            cnt_q   <= CNT_W'(0);
            insn_q  <= BUBBLE;
            valid_q <= 1'b0;
            opc_q   <= PC_W'(0);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            insn_q  <= insn_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (iBranchTaken) begin
            state_d = S_RUN;
        end else if (!iStall) begin
            case (state_q)
                S_RUN: begin
                    if (fetch_is_delay) begin
                        state_d = S_DELAY;
                    end
                end
                S_DELAY: begin
                    // Last counted cycle: fetch resumes on the next edge.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // Datapath/output next values; default is to hold everything (stall).
    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        insn_d  = insn_q;
        valid_d = valid_q;
        opc_d   = opc_q;

        if (iBranchTaken) begin
            // Word at the old PC is dropped; target is fetched next edge.
            pc_d    = iBranchTarget;
            cnt_d   = CNT_W'(0);
            insn_d  = BUBBLE;
            valid_d = 1'b0;
        end else if (!iStall) begin
            case (state_q)
                S_RUN: begin
                    pc_d = pc_q + PC_W'(1);
                    if (fetch_is_nop) begin
                        insn_d  = BUBBLE;
                        valid_d = 1'b0;
                        if (fetch_is_delay) begin
                            cnt_d = fetch_imm;
                        end
                    end else begin
                        insn_d  = iInstruction;
                        valid_d = 1'b1;
                        opc_d   = pc_q;
                    end
                end
                S_DELAY: begin
                    insn_d  = BUBBLE;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
                default: begin
                    insn_d  = BUBBLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Busy mirrors the state that will be held after this edge.
    always_comb begin
        busy_d = (state_d == S_DELAY);
    end

    assign oAddress     = pc_q;
    assign oInstruction = insn_q;
    assign oValid       = valid_q;
    assign oPC          = opc_q;
    assign oDelayBusy   = busy_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [3:0]  NOP = 4'd0;
    localparam logic [27:0] BUB = {NOP, 24'd0};

    logic        Clock;
    logic        Reset;
    logic [27:0] iInstruction;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        iStall;
    logic [15:0] oAddress;
    logic [27:0] oInstruction;
    logic        oValid;
    logic [15:0] oPC;
    logic        oDelayBusy;

    instruction_fetch #(.OP_NOP(NOP), .BUBBLE(BUB)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iInstruction (iInstruction),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .iStall       (iStall),
        .oAddress     (oAddress),
        .oInstruction (oInstruction),
        .oValid       (oValid),
        .oPC          (oPC),
        .oDelayBusy   (oDelayBusy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Program ROM, aliased every 256 words.
    logic [27:0] rom [256];
    always_comb iInstruction = rom[oAddress[7:0]];

    int tests = 0;
    int fails = 0;

    // Reference model: PC, last issued word, and remaining hold cycles.
    logic [15:0] m_pc;
    logic [15:0] m_opc;
    logic [27:0] m_inst;
    logic        m_valid;
    int          m_wait;

    function automatic logic [27:0] add_w(input int i);
        return {4'h1, 24'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [27:0] w;
        if (Reset) begin
            m_pc = 16'd0; m_opc = 16'd0; m_inst = BUB; m_valid = 1'b0; m_wait = 0;
        end else if (iBranchTaken) begin
            m_pc = iBranchTarget; m_inst = BUB; m_valid = 1'b0; m_wait = 0;
        end else if (iStall) begin
            // everything holds
        end else if (m_wait > 0) begin
            m_wait--; m_inst = BUB; m_valid = 1'b0;
        end else begin
            w = rom[m_pc[7:0]];
            if (w[27:24] == NOP) begin
                m_inst = BUB; m_valid = 1'b0; m_wait = int'(w[23:0]);
            end else begin
                m_inst = w; m_valid = 1'b1; m_opc = m_pc;
            end
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic compare();
        chk("oAddress", 32'(oAddress), 32'(m_pc));
        chk("oValid", 32'(oValid), 32'(m_valid));
        chk("oInstruction", 32'(oInstruction), 32'(m_inst));
        chk("oDelayBusy", 32'(oDelayBusy), 32'(m_wait != 0));
        if (m_valid) chk("oPC", 32'(oPC), 32'(m_opc));
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic step(input logic r, input logic b, input logic [15:0] t, input logic s);
        Reset = r; iBranchTaken = b; iBranchTarget = t; iStall = s;
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        compare();
    endtask

    initial begin
        int nv, nb;
        logic [15:0] a_hold;
        logic [27:0] i_hold;
        logic [15:0] tgt;

        Reset = 1'b1; iBranchTaken = 1'b0; iBranchTarget = 16'd0; iStall = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = add_w(i);

        // Reset values and straight-line fetch.
        step(1, 0, 0, 0);
        chk("lit_rst_addr", 32'(oAddress), 32'd0);
        chk("lit_rst_valid", 32'(oValid), 32'd0);
        chk("lit_rst_inst", 32'(oInstruction), 32'(BUB));
        chk("lit_rst_busy", 32'(oDelayBusy), 32'd0);
        chk("lit_rst_pc", 32'(oPC), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0);
            chk("lit_seq_addr", 32'(oAddress), 32'(k));
            chk("lit_seq_pc", 32'(oPC), 32'(k - 1));
            chk("lit_seq_valid", 32'(oValid), 32'd1);
        end

        // NOP with immediate 3.
        rom[0] = {NOP, 24'd3};
        step(1, 0, 0, 0);
        nv = 0; nb = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            if (!oValid) nv++;
            if (oDelayBusy) nb++;
        end
        chk("lit_nop3_invalid_cycles", 32'(nv), 32'd4);
        chk("lit_nop3_busy_cycles", 32'(nb), 32'd3);
        step(0, 0, 0, 0);
        chk("lit_nop3_valid", 32'(oValid), 32'd1);
        chk("lit_nop3_pc", 32'(oPC), 32'd1);
        chk("lit_nop3_inst", 32'(oInstruction), 32'h1000001);
        rom[0] = add_w(0);

        // Branch to 6 while PC=10.
        step(0, 1, 16'd10, 0);
        chk("lit_br_setup", 32'(oAddress), 32'd10);
        step(0, 1, 16'd6, 0);
        chk("lit_br_valid", 32'(oValid), 32'd0);
        chk("lit_br_addr", 32'(oAddress), 32'd6);
        step(0, 0, 16'd99, 0);
        chk("lit_br_issue_valid", 32'(oValid), 32'd1);
        chk("lit_br_issue_pc", 32'(oPC), 32'd6);

        // Wrap at 16'hFFFF.
        step(0, 1, 16'hFFFF, 0);
        chk("lit_wrap_addr0", 32'(oAddress), 32'hFFFF);
        step(0, 0, 0, 0);
        chk("lit_wrap_addr1", 32'(oAddress), 32'd0);
        chk("lit_wrap_pc", 32'(oPC), 32'hFFFF);

        // Branch to the current PC refetches it.
        step(0, 1, 16'd0, 0);
        step(0, 0, 0, 0);
        chk("lit_self_br_pc", 32'(oPC), 32'd0);
        chk("lit_self_br_addr", 32'(oAddress), 32'd1);

        // Stall during a 5-cycle delay, then mid-stream.
        rom[0] = {NOP, 24'd5};
        step(1, 0, 0, 0);
        nb = 0;
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0);
            if (oDelayBusy) nb++;
        end
        a_hold = oAddress;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1);
            if (oDelayBusy) nb++;
            chk("lit_dstall_addr", 32'(oAddress), 32'(a_hold));
        end
        for (int k = 0; k < 20 && !oValid; k++) begin
            step(0, 0, 0, 0);
            if (oDelayBusy) nb++;
        end
        chk("lit_dstall_busy_cycles", 32'(nb), 32'd8);
        chk("lit_dstall_pc", 32'(oPC), 32'd1);
        step(0, 0, 0, 0);
        i_hold = oInstruction;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1);
            chk("lit_stall_pc", 32'(oPC), 32'd2);
            chk("lit_stall_inst", 32'(oInstruction), 32'(i_hold));
        end
        step(0, 0, 0, 0);
        chk("lit_stall_resume_pc", 32'(oPC), 32'd3);
        rom[0] = add_w(0);

        // Reset during a long delay, with branch and stall also asserted.
        rom[0] = {NOP, 24'd4000};
        step(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
        chk("lit_long_busy", 32'(oDelayBusy), 32'd1);
        rom[0] = add_w(0);
        step(1, 1, 16'h0055, 1);
        chk("lit_rstd_addr", 32'(oAddress), 32'd0);
        chk("lit_rstd_valid", 32'(oValid), 32'd0);
        chk("lit_rstd_busy", 32'(oDelayBusy), 32'd0);
        chk("lit_rstd_inst", 32'(oInstruction), 32'(BUB));
        step(0, 0, 0, 0);
        chk("lit_rstd_refetch_pc", 32'(oPC), 32'd0);
        chk("lit_rstd_refetch_valid", 32'(oValid), 32'd1);

        // Randomized program and control.
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 99) < 15)
                rom[i] = {NOP, 24'($urandom_range(0, 6))};
            else
                rom[i] = {4'($urandom_range(1, 15)), 24'($urandom)};
        end
        step(1, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 3))
                0:       tgt = m_pc;
                1:       tgt = 16'hFFF8 + 16'($urandom_range(0, 7));
                default: tgt = 16'($urandom);
            endcase
            step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, tgt,
                 $urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
